ct_f_spsram_512x144_ctrl: RTL and testbench

Request/response access controller that sits directly upstream of the 512x144 single-port SRAM macro and drives its A/CEN/GWEN/WEN/D pins. After reset it zero-fills the whole array with a hardware init walk. It then accepts one read or bit-masked write per cycle on a valid/ready request port. Read data returns in order through a small response FIFO with its own valid/ready handshake.

---
 rtl/ct_f_spsram_512x144_ctrl.sv | 152 +++++++++++++++
 tb/tb_ct_f_spsram_512x144_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_512x144_ctrl.sv
// Request/response controller in front of a single-port SRAM macro: zero-fills the array
// after reset, then serves one read or bit-masked write per cycle with in-order read data.
module ct_f_spsram_512x144_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144,
  parameter int INIT_EN    = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rd_inflight_q, rd_inflight_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];

  logic [CNT_W:0]          credit_used;
  logic                    acc;
  logic                    acc_rd;
  logic                    push;
  logic                    pop;

  // A read occupies a credit from acceptance until its data leaves the FIFO, so a push
  // can never land on a full FIFO.
  assign credit_used = (CNT_W+1)'(count_q) + (CNT_W+1)'(rd_inflight_q);
  assign req_rdy     = (state_q == S_RUN) && (credit_used < (CNT_W+1)'(RSP_DEPTH));
  assign acc         = req_vld & req_rdy;
  assign acc_rd      = acc & ~req_wr;
  assign push        = rd_inflight_q;
  assign rsp_vld     = (count_q != '0);
  assign pop         = rsp_vld & rsp_rdy;
  assign rsp_rdata   = fifo_mem[rd_ptr_q];
  assign init_done   = init_done_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_RST;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= Q;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      S_RST: begin
        if (INIT_EN != 0) begin
          state_d = S_INIT;
        end else begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    A    = '0;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    D    = '0;
    case (state_q)
      S_INIT: begin
        A    = init_cnt_q;
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
      end
      S_RUN: begin
        if (acc) begin
          A   = req_addr;
          CEN = 1'b0;
          if (req_wr) begin
            GWEN = 1'b0;
            WEN  = ~req_wmask;
            D    = req_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_inflight_d = acc_rd;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  a_no_push_on_full : assert property (@(posedge CLK) disable iff (RST)
    !(push && (count_q == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_ct_f_spsram_512x144_ctrl.sv
// Bench for ct_f_spsram_512x144_ctrl: SRAM macro model, cycle-level reference model with
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_ct_f_spsram_512x144_ctrl;

  localparam int AW         = 9;
  localparam int DW         = 144;
  localparam int DEPTH      = 512;
  localparam int INIT_EDGES = DEPTH + 1;
  localparam int CREDITS    = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [DW-1:0] WEN, D, Q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  ct_f_spsram_512x144_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM macro: unwritten words hold address-dependent garbage so the zero-fill is visible.
  bit [DW-1:0] sram    [DEPTH];
  bit          sram_wr [DEPTH];

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return sram_wr[a] ? sram[a] : {16{a ^ 9'h15A}};
  endfunction

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        sram[A]    <= (sram_word(A) & WEN) | (D & ~WEN);
        sram_wr[A] <= 1'b1;
      end else begin
        Q <= sram_word(A);
      end
    end
  end

  // Reference model: edge count since reset release, golden memory, expected response queue.
  int          cyc;
  bit [DW-1:0] ref_mem [DEPTH];
  bit          rd_pipe_v;
  bit [DW-1:0] rd_pipe_d;
  bit [DW-1:0] exp_q [$];

  function automatic bit exp_rdy();
    return (cyc >= INIT_EDGES) && ((exp_q.size() + int'(rd_pipe_v)) < CREDITS);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc       <= 0;
      rd_pipe_v <= 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
    end else begin
      if (req_vld && exp_rdy()) begin
        if (req_wr) begin
          ref_mem[req_addr] <= (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
          rd_pipe_v <= 1'b0;
        end else begin
          rd_pipe_v <= 1'b1;
          rd_pipe_d <= ref_mem[req_addr];
        end
      end else begin
        rd_pipe_v <= 1'b0;
      end
      if (exp_q.size() != 0 && rsp_rdy) void'(exp_q.pop_front());
      if (rd_pipe_v) exp_q.push_back(rd_pipe_d);
      if (cyc < 100000) cyc <= cyc + 1;
    end
  end

  always @(negedge CLK) begin
    check("req_rdy", DW'(req_rdy), DW'(exp_rdy()));
    check("init_done", DW'(init_done), DW'(cyc >= INIT_EDGES));
    check("rsp_vld", DW'(rsp_vld), DW'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("rsp_rdata", rsp_rdata, exp_q[0]);
    if (cyc >= 1 && cyc <= DEPTH) begin
      check("init_A", DW'(A), DW'(cyc - 1));
      check("init_CEN", DW'(CEN), DW'(0));
      check("init_GWEN", DW'(GWEN), DW'(0));
      check("init_WEN", WEN, '0);
      check("init_D", D, '0);
    end else if (req_vld && exp_rdy()) begin
      check("acc_A", DW'(A), DW'(req_addr));
      check("acc_CEN", DW'(CEN), DW'(0));
      check("acc_GWEN", DW'(GWEN), DW'(!req_wr));
      check("acc_WEN", WEN, req_wr ? ~req_wmask : '1);
      if (req_wr) check("acc_D", D, req_wdata);
    end else begin
      check("idle_A", DW'(A), DW'(0));
      check("idle_CEN", DW'(CEN), DW'(1));
      check("idle_GWEN", DW'(GWEN), DW'(1));
      check("idle_WEN", WEN, '1);
      check("idle_D", D, '0);
    end
  end

  // Monitors: popped responses with their cycle stamps, and init-write cycles.
  bit [DW-1:0] rsp_log [$];
  int          rsp_cyc [$];
  int          init_wr_seen;

  always @(negedge CLK) begin
    if (!RST && rsp_vld && rsp_rdy) begin
      rsp_log.push_back(rsp_rdata);
      rsp_cyc.push_back(cyc);
    end
  end

  always @(negedge CLK or posedge RST) begin
    if (RST) init_wr_seen <= 0;
    else if (!CEN && !GWEN && WEN == '0 && !init_done) init_wr_seen <= init_wr_seen + 1;
  end

  function automatic logic [DW-1:0] pat(input int i);
    return {DW'(32'hA500_0000 + i * 32'h0101), 16'h0};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req_vld   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [DW-1:0] wm);
    int n = 0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
    while (!req_rdy && n < 50) begin step(); n++; end
    check("req_accept", DW'(req_rdy), DW'(1));
    step();
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d);
    int n = 0;
    while (!rsp_vld && n < 50) begin step(); n++; end
    check("rsp_arrive", DW'(rsp_vld), DW'(1));
    d = rsp_rdata;
    step();
  endtask

  task automatic run_init();
    repeat (DEPTH) step();
    check("init_done_before_513", DW'(init_done), DW'(0));
    check("req_rdy_before_513", DW'(req_rdy), DW'(0));
    step();
    check("init_done_at_513", DW'(init_done), DW'(1));
    check("req_rdy_at_513", DW'(req_rdy), DW'(1));
    check("init_write_cycles", DW'(init_wr_seen), DW'(DEPTH));
  endtask

  logic [DW-1:0] rd;
  int            base, acc_cnt, addr_i;
  bit            r;

  initial begin
    RST = 1'b1; rsp_rdy = 1'b1; idle();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    run_init();

    send(0, 9'h010, '0, '0); idle();
    wait_rsp(rd);
    check("init_zero_read", rd, '0);

    send(1, 9'h005, DW'(16'h1234), '1);
    send(0, 9'h005, '0, '0); idle();
    check("rd_lat_edge_n", DW'(rsp_vld), DW'(0));
    step();
    check("rd_lat_edge_n1", DW'(rsp_vld), DW'(1));
    check("raw_data", rsp_rdata, DW'(16'h1234));
    step();

    req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h1FF; req_wdata = '1; req_wmask = DW'(16'h00FF);
    #1;
    check("masked_WEN", WEN, ~DW'(16'h00FF));
    check("masked_A", DW'(A), DW'(9'h1FF));
    step(); idle();
    send(0, 9'h1FF, '0, '0); idle();
    wait_rsp(rd);
    check("masked_read", rd, DW'(16'h00FF));

    for (int i = 0; i < 16; i++) send(1, AW'(i), pat(i), '1);
    idle();
    base = rsp_log.size();
    for (int i = 0; i < 16; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(i);
      check("stream_rdy", DW'(req_rdy), DW'(1));
      step();
    end
    idle();
    repeat (4) step();
    check("stream_count", DW'(rsp_log.size() - base), DW'(16));
    if (rsp_log.size() - base >= 16) begin
      for (int i = 0; i < 16; i++) begin
        check("stream_data", rsp_log[base+i], pat(i));
        if (i > 0) check("stream_consec", DW'(rsp_cyc[base+i] - rsp_cyc[base+i-1]), DW'(1));
      end
    end

    rsp_rdy = 1'b0; base = rsp_log.size(); acc_cnt = 0; addr_i = 0;
    for (int k = 0; k < 10; k++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(addr_i);
      if (rsp_vld) check("stall_head_stable", rsp_rdata, pat(0));
      r = req_rdy;
      step();
      if (r) begin acc_cnt++; addr_i++; end
    end
    idle();
    check("stall_accepts", DW'(acc_cnt), DW'(4));
    check("stall_rdy_low", DW'(req_rdy), DW'(0));
    check("stall_rsp_vld", DW'(rsp_vld), DW'(1));
    rsp_rdy = 1'b1;
    repeat (6) step();
    check("drain_count", DW'(rsp_log.size() - base), DW'(4));
    if (rsp_log.size() - base >= 4)
      for (int i = 0; i < 4; i++) check("drain_data", rsp_log[base+i], pat(i));

    base = rsp_log.size();
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h000;
    step();
    req_addr = 9'h001;
    step();
    idle();
    RST = 1'b1;
    #1;
    check("rst_rsp_vld", DW'(rsp_vld), DW'(0));
    check("rst_init_done", DW'(init_done), DW'(0));
    check("rst_req_rdy", DW'(req_rdy), DW'(0));
    check("rst_CEN", DW'(CEN), DW'(1));
    check("rst_GWEN", DW'(GWEN), DW'(1));
    check("rst_WEN", WEN, '1);
    check("rst_A", DW'(A), DW'(0));
    repeat (2) step();
    RST = 1'b0;
    run_init();
    check("no_stale_rsp", DW'(rsp_log.size() - base), DW'(0));
    send(0, 9'h005, '0, '0); idle();
    wait_rsp(rd);
    check("reinit_zero_5", rd, '0);
    send(0, 9'h1FF, '0, '0); idle();
    wait_rsp(rd);
    check("reinit_zero_1ff", rd, '0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
